// File: rtl/digital_screen_pkg.sv
// Shared scan-state type, blank segment pattern and slot-length helper
// for the multiplexed seven-segment display driver.
package digital_screen_pkg;

    typedef enum logic {ST_BLANK, ST_ON} scan_state_t;

    localparam logic [7:0] HEX_OFF = 8'hFF;

    function automatic int slot_len(input int blank_cycles, input int step_cycles,
                                    input int bright_w);
        return blank_cycles + (2 ** bright_w) * step_cycles;
    endfunction

endpackage

// File: rtl/digital_screen_pwm_seg7.sv
// Hex nibble to active-low seven-segment pattern, bit order gfedcba.
module digital_screen_pwm_seg7 (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/digital_screen_pwm.sv
// Multiplexed seven-segment scan driver with dead-time blanking, PWM brightness,
// per-digit blink and frame-synchronous double-buffered display data.
module digital_screen_pwm
    import digital_screen_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 64,
    parameter int STEP_CYCLES  = 256,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [NUM_DIGITS-1:0]      en,
    input  logic [NUM_DIGITS-1:0][3:0] display,
    input  logic [NUM_DIGITS-1:0]      dots,
    input  logic [NUM_DIGITS-1:0]      blink,
    input  logic [BRIGHT_W-1:0]        brightness,
    input  logic                       load,
    output logic [NUM_DIGITS-1:0]      AN,
    output logic [7:0]                 HEX,
    output logic                       frame_done
);

    localparam int SLOT_LEN  = slot_len(BLANK_CYCLES, STEP_CYCLES, BRIGHT_W);
    localparam int ON_CYCLES = SLOT_LEN - BLANK_CYCLES;
    localparam int CNT_MAX   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int SEL_W     = $clog2(NUM_DIGITS);
    localparam int FRAME_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    scan_state_t                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [BRIGHT_W-1:0]         duty_q, duty_d;
    logic [FRAME_W-1:0]          frameCnt_q, frameCnt_d;
    logic                        blinkPhase_q, blinkPhase_d;
    logic [NUM_DIGITS-1:0][3:0]  dispAct_q, dispAct_d, dispPend_q, dispPend_d;
    logic [NUM_DIGITS-1:0]       dotsAct_q, dotsAct_d, dotsPend_q, dotsPend_d;
    logic                        pendValid_q, pendValid_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [7:0]                  hex_q, hex_d;
    logic                        frameDone_q, frameDone_d;

    logic        blankLast, onLast, frameEnd, lit;
    logic [31:0] onLimit;
    logic [6:0]  segCode;

    digital_screen_pwm_seg7 u_seg7 (
        .nibble_i (dispAct_q[sel_q]),
        .seg_o    (segCode)
    );

    assign blankLast = (state_q == ST_BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign onLast    = (state_q == ST_ON) && (cnt_q == CNT_W'(ON_CYCLES - 1));
    assign frameEnd  = onLast && (sel_q == SEL_W'(NUM_DIGITS - 1));
    assign onLimit   = 32'(duty_q) * 32'(STEP_CYCLES);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        sel_d        = sel_q;
        duty_d       = duty_q;
        frameCnt_d   = frameCnt_q;
        blinkPhase_d = blinkPhase_q;
        dispAct_d    = dispAct_q;
        dotsAct_d    = dotsAct_q;
        dispPend_d   = dispPend_q;
        dotsPend_d   = dotsPend_q;
        pendValid_d  = pendValid_q;

        if (state_q == ST_BLANK) begin
            if (blankLast) begin
                state_d = ST_ON;
                cnt_d   = '0;
                duty_d  = brightness;
            end
        end else begin
            if (onLast) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                sel_d   = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
            end
        end

        if (frameEnd) begin
            if (pendValid_q) begin
                dispAct_d   = dispPend_q;
                dotsAct_d   = dotsPend_q;
                pendValid_d = 1'b0;
            end
            if (frameCnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frameCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                frameCnt_d = frameCnt_q + FRAME_W'(1);
            end
        end

        // A load on the boundary cycle lands after the commit above, so it waits a frame.
        if (load) begin
            dispPend_d  = display;
            dotsPend_d  = dots;
            pendValid_d = 1'b1;
        end

        lit = (state_q == ST_ON) && (32'(cnt_q) < onLimit) && en[sel_q]
              && !(blink[sel_q] && blinkPhase_q);
        an_d        = lit ? ~(NUM_DIGITS'(1) << sel_q) : '1;
        hex_d       = lit ? {~dotsAct_q[sel_q], segCode} : HEX_OFF;
        frameDone_d = frameEnd;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            sel_q        <= '0;
            duty_q       <= '0;
            frameCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            dispAct_q    <= '0;
            dotsAct_q    <= '0;
            dispPend_q   <= '0;
            dotsPend_q   <= '0;
            pendValid_q  <= 1'b0;
            an_q         <= '1;
            hex_q        <= HEX_OFF;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            duty_q       <= duty_d;
            frameCnt_q   <= frameCnt_d;
            blinkPhase_q <= blinkPhase_d;
            dispAct_q    <= dispAct_d;
            dotsAct_q    <= dotsAct_d;
            dispPend_q   <= dispPend_d;
            dotsPend_q   <= dotsPend_d;
            pendValid_q  <= pendValid_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            frameDone_q  <= frameDone_d;
        end
    end

    assign AN         = an_q;
    assign HEX        = hex_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_digital_screen_pwm.sv
// Directed bench for digital_screen_pwm: 4 digits, 6-cycle slots, 24-cycle frames.
`timescale 1ns/1ps
module tb_digital_screen_pwm;

    localparam int ND    = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = 6;
    localparam int FRAME = 24;

    logic             clk = 1'b0;
    logic             clr_n = 1'b1;
    logic [ND-1:0]    en = '0;
    logic [ND-1:0][3:0] display = '0;
    logic [ND-1:0]    dots = '0;
    logic [ND-1:0]    blink = '0;
    logic [1:0]       brightness = '0;
    logic             load = 1'b0;
    logic [ND-1:0]    AN;
    logic [7:0]       HEX;
    logic             frame_done;

    int compareCount  = 0;
    int mismatchCount = 0;
    int frameIdx      = 0;

    digital_screen_pwm #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (2),
        .STEP_CYCLES  (1),
        .BRIGHT_W     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .display    (display),
        .dots       (dots),
        .blink      (blink),
        .brightness (brightness),
        .load       (load),
        .AN         (AN),
        .HEX        (HEX),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] enV, input logic [3:0] blinkV, input logic [1:0] brightV);
        en         = enV;
        blink      = blinkV;
        brightness = brightV;
    endtask

    task automatic loadDisplay(input logic [3:0][3:0] dispV, input logic [3:0] dotsV);
        display = dispV;
        dots    = dotsV;
        load    = 1'b1;
        stepClock();
        load    = 1'b0;
    endtask

    task automatic waitFrameDone();
        bit found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            stepClock();
            if (frame_done === 1'b1) found = 1'b1;
        end
        if (!found) checkOutput("frame_done timeout", 32'd0, 32'd1);
    endtask

    // Checks one whole frame, starting just after the previous frame_done sample.
    task automatic checkFrame(input string tag, input int litCycles, input logic [3:0][7:0] hexExp,
                              input int loadAt, input logic [3:0][3:0] loadVal, input logic [3:0] loadDots);
        bit phase = ((frameIdx / 2) % 2) == 1;
        for (int i = 0; i < FRAME; i++) begin
            int   slot;
            int   ofs;
            bit   isLit;
            logic [3:0] anExp;
            logic [7:0] hexE;
            if (i == loadAt) begin
                display = loadVal;
                dots    = loadDots;
                load    = 1'b1;
            end
            stepClock();
            load  = 1'b0;
            slot  = i / SLOT;
            ofs   = i % SLOT;
            isLit = (ofs >= BLANK) && ((ofs - BLANK) < litCycles) && (en[slot] == 1'b1)
                    && !(blink[slot] == 1'b1 && phase);
            anExp = isLit ? ~(4'(1) << slot) : 4'hF;
            hexE  = isLit ? hexExp[slot] : 8'hFF;
            checkOutput($sformatf("%s f%0d c%0d AN", tag, frameIdx, i), 32'(AN), 32'(anExp));
            checkOutput($sformatf("%s f%0d c%0d HEX", tag, frameIdx, i), 32'(HEX), 32'(hexE));
            checkOutput($sformatf("%s f%0d c%0d frame_done", tag, frameIdx, i),
                        32'(frame_done), (i == FRAME - 1) ? 32'd1 : 32'd0);
        end
        frameIdx++;
    endtask

    initial begin
        logic [3:0][7:0] hexOnes;
        hexOnes = {8'hF9, 8'h79, 8'hF9, 8'hF9};

        #2 clr_n = 1'b0;
        repeat (3) stepClock();
        checkOutput("reset AN", 32'(AN), 32'hF);
        checkOutput("reset HEX", 32'(HEX), 32'hFF);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        clr_n = 1'b1;
        stepClock();
        checkOutput("release AN", 32'(AN), 32'hF);
        checkOutput("release HEX", 32'(HEX), 32'hFF);
        checkOutput("release frame_done", 32'(frame_done), 32'd0);

        applyStimulus(4'hF, 4'h0, 2'd3);
        loadDisplay({4'h3, 4'h2, 4'h1, 4'h0}, 4'h0);
        waitFrameDone();
        frameIdx = 1;

        checkFrame("commit", 3, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, -1, '0, '0);
        applyStimulus(4'hF, 4'h0, 2'd0);
        checkFrame("bright0", 0, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, -1, '0, '0);
        applyStimulus(4'hF, 4'h0, 2'd1);
        checkFrame("bright1", 1, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, -1, '0, '0);
        applyStimulus(4'hF, 4'h0, 2'd3);
        checkFrame("midload", 3, {8'hB0, 8'hA4, 8'hF9, 8'hC0}, 13, {4'hF, 4'hF, 4'hF, 4'hF}, 4'h0);
        checkFrame("loadF", 3, {8'h8E, 8'h8E, 8'h8E, 8'h8E}, 23, {4'h1, 4'h1, 4'h1, 4'h1}, 4'b0100);
        checkFrame("boundload", 3, {8'h8E, 8'h8E, 8'h8E, 8'h8E}, -1, '0, '0);
        checkFrame("ones", 3, hexOnes, -1, '0, '0);

        applyStimulus(4'hF, 4'b0010, 2'd3);
        for (int f = 0; f < 6; f++) checkFrame("blink", 3, hexOnes, -1, '0, '0);

        applyStimulus(4'b1010, 4'h0, 2'd3);
        checkFrame("enable", 3, hexOnes, -1, '0, '0);

        applyStimulus(4'hF, 4'h0, 2'd3);
        repeat (3) stepClock();
        checkOutput("preRst AN", 32'(AN), 32'b1110);
        checkOutput("preRst HEX", 32'(HEX), 32'hF9);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("asyncRst AN", 32'(AN), 32'hF);
        checkOutput("asyncRst HEX", 32'(HEX), 32'hFF);
        checkOutput("asyncRst frame_done", 32'(frame_done), 32'd0);
        repeat (2) stepClock();
        clr_n = 1'b1;
        frameIdx = 0;
        checkFrame("postRst", 3, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, -1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
